crossbar_arbiter: RTL and testbench

Per-output round-robin route allocator for the NxN crossbar switch. It collects per-input packet requests, each carrying a destination output index, and grants every output to at most one input at a time. It drives the per-output `route[j]` index that the crossbar select decoder turns into the one-hot switch-enable matrix. Each grant is held for a whole packet, up to and including the beat marked `req_last`, and is then released.

---
 rtl/crossbar_arbiter.sv | 95 +++++++++
 tb/tb_crossbar_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Per-output round-robin route allocator: grant in 1 cycle, lock held through the req_last beat.
// Backpressure: a locked winner sees req_ready only while its output's out_ready is high.
module crossbar_arbiter #(
    parameter int N = 8,
    localparam int ROUTE_BITS = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_valid,
    input  logic [N*ROUTE_BITS-1:0] req_dest,
    input  logic [N-1:0]            req_last,
    output logic [N-1:0]            req_ready,
    input  logic [N-1:0]            out_ready,
    output logic [N*ROUTE_BITS-1:0] route,
    output logic [N-1:0]            route_valid
);

    localparam int IW = ROUTE_BITS + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q [N];
    logic [ROUTE_BITS-1:0] win_q   [N];
    logic [ROUTE_BITS-1:0] ptr_q   [N];
    logic [ROUTE_BITS-1:0] win_d   [N];
    logic [N-1:0]          grant_d;
    logic [N-1:0]          release_d;
    logic [IW-1:0]         cand;

    // Scan downwards so the last hit, i.e. the first requester from ptr, wins.
    always_comb begin
        cand = '0;
        for (int j = 0; j < N; j++) begin
            grant_d[j] = 1'b0;
            win_d[j]   = '0;
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, ptr_q[j]} + IW'(k);
                if (cand >= IW'(N)) begin
                    cand = cand - IW'(N);
                end
                if (req_valid[cand[ROUTE_BITS-1:0]] &&
                    req_dest[int'(cand[ROUTE_BITS-1:0]) * ROUTE_BITS +: ROUTE_BITS] == ROUTE_BITS'(j)) begin
                    grant_d[j] = 1'b1;
                    win_d[j]   = cand[ROUTE_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        release_d = '0;
        for (int j = 0; j < N; j++) begin
            if (state_q[j] == LOCKED && out_ready[j] && req_valid[win_q[j]]) begin
                req_ready[win_q[j]] = 1'b1;
                release_d[j]        = req_last[win_q[j]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= IDLE;
                win_q[j]   <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                case (state_q[j])
                    IDLE: begin
                        if (grant_d[j]) begin
                            state_q[j] <= LOCKED;
                            win_q[j]   <= win_d[j];
                        end
                    end
                    LOCKED: begin
                        if (release_d[j]) begin
                            state_q[j] <= IDLE;
                            ptr_q[j]   <= (win_q[j] == ROUTE_BITS'(N - 1)) ? '0
                                          : win_q[j] + ROUTE_BITS'(1);
                        end
                    end
                    default: state_q[j] <= IDLE;
                endcase
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign route[j*ROUTE_BITS +: ROUTE_BITS] = win_q[j];
        assign route_valid[j]                    = (state_q[j] == LOCKED);
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Scoreboarded bench for crossbar_arbiter: an 8-port and a 6-port instance share clock and reset.
module tb_crossbar_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  v8, l8, o8, r8, rv8;
    logic [23:0] d8, rt8;
    logic [5:0]  v6, l6, o6, r6, rv6;
    logic [17:0] d6, rt6;

    int left [2][8];
    int pkts [2][8];
    int plen [2][8];
    int dst  [2][8];
    bit acc  [2][8];
    int exp_q [16][$];
    int n_checks = 0;
    int n_err    = 0;

    crossbar_arbiter #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(v8), .req_dest(d8), .req_last(l8),
        .req_ready(r8), .out_ready(o8), .route(rt8), .route_valid(rv8)
    );

    crossbar_arbiter #(.N(6)) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_dest(d6), .req_last(l6),
        .req_ready(r6), .out_ready(o6), .route(rt6), .route_valid(rv6)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic bit vld(input int d, input int i);
        return (d == 0) ? v8[i] : v6[i];
    endfunction

    function automatic bit rdy(input int d, input int i);
        return (d == 0) ? r8[i] : r6[i];
    endfunction

    task automatic apply();
        for (int i = 0; i < 8; i++) begin
            v8[i]         = pkts[0][i] > 0;
            l8[i]         = left[0][i] == 1;
            d8[i*3 +: 3]  = 3'(dst[0][i]);
        end
        for (int i = 0; i < 6; i++) begin
            v6[i]         = pkts[1][i] > 0;
            l6[i]         = left[1][i] == 1;
            d6[i*3 +: 3]  = 3'(dst[1][i]);
        end
    endtask

    // Advance one clock; senders consume the beats accepted at the previous sample point.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                if (acc[d][i] && pkts[d][i] > 0) begin
                    left[d][i]--;
                    if (left[d][i] == 0) begin
                        pkts[d][i]--;
                        if (pkts[d][i] > 0) left[d][i] = plen[d][i];
                    end
                end
            end
        end
        apply();
    endtask

    task automatic send(input int d, input int i, input int dest, input int len, input int n);
        dst[d][i]  = dest;
        plen[d][i] = len;
        left[d][i] = len;
        pkts[d][i] = n;
        apply();
    endtask

    task automatic abandon(input int d, input int i);
        pkts[d][i] = 0;
        left[d][i] = 0;
        apply();
    endtask

    task automatic expect_beats(input int d, input int j, input int i, input int n);
        for (int k = 0; k < n; k++) exp_q[d*8 + j].push_back(i);
    endtask

    task automatic wait_idle();
        int  k;
        bit  busy;
        k = 0;
        busy = 1'b1;
        while (busy && k < 300) begin
            cyc();
            k++;
            busy = (rv8 != 0) || (rv6 != 0);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 8; i++)
                    if (pkts[d][i] > 0) busy = 1'b1;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    // Every accepted beat must match the next expected winner for its output.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < ((d == 0) ? 8 : 6); i++) begin
                acc[d][i] = vld(d, i) && rdy(d, i);
                if (acc[d][i]) begin
                    if (dst[d][i] >= ((d == 0) ? 8 : 6))
                        check($sformatf("xfer_bad_dest_d%0d", d), i, -1);
                    else if (exp_q[d*8 + dst[d][i]].size() == 0)
                        check($sformatf("xfer_extra_d%0d_o%0d", d, dst[d][i]), i, -1);
                    else
                        check($sformatf("xfer_d%0d_o%0d", d, dst[d][i]), i,
                              exp_q[d*8 + dst[d][i]].pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "time limit");
    end

    int rv_pat [13] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};

    initial begin
        rst = 1'b1;
        o8  = '1;
        o6  = '1;
        apply();
        repeat (2) cyc();
        @(negedge clk);
        check("rst_rv8", int'(rv8), 0);
        check("rst_rdy8", int'(r8), 0);
        check("rst_rt8", int'(rt8), 0);
        check("rst_rv6", int'(rv6), 0);
        check("rst_rt6", int'(rt6), 0);
        cyc();
        rst = 1'b0;

        // single 1-beat packet, input 3 -> output 5
        send(0, 3, 5, 1, 1);
        expect_beats(0, 5, 3, 1);
        @(negedge clk);
        check("t1_rv_pre", int'(rv8[5]), 0);
        cyc();
        @(negedge clk);
        check("t1_route", int'(rt8[15 +: 3]), 3);
        check("t1_rv", int'(rv8[5]), 1);
        check("t1_rdy", int'(r8[3]), 1);
        cyc();
        @(negedge clk);
        check("t1_release", int'(rv8[5]), 0);
        wait_idle();

        // round robin on output 1: 0, 2, 7, 0 with one idle cycle between packets
        send(0, 0, 1, 2, 2);
        send(0, 2, 1, 2, 1);
        send(0, 7, 1, 2, 1);
        expect_beats(0, 1, 0, 2);
        expect_beats(0, 1, 2, 2);
        expect_beats(0, 1, 7, 2);
        expect_beats(0, 1, 0, 2);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check($sformatf("t2_rv_c%0d", k), int'(rv8[1]), rv_pat[k]);
            cyc();
        end
        wait_idle();

        // backpressure on a 4-beat packet, input 4 -> output 0
        send(0, 4, 0, 4, 1);
        expect_beats(0, 0, 4, 4);
        @(negedge clk);
        check("t3_rv_pre", int'(rv8[0]), 0);
        cyc();
        @(negedge clk);
        check("t3_rdy_beat1", int'(r8[4]), 1);
        cyc();
        o8[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t3_stall_rdy%0d", k), int'(r8[4]), 0);
            check($sformatf("t3_stall_route%0d", k), int'(rt8[0 +: 3]), 4);
            check($sformatf("t3_stall_rv%0d", k), int'(rv8[0]), 1);
            cyc();
        end
        o8[0] = 1'b1;
        wait_idle();

        // parallel: input i -> output 7-i
        for (int i = 0; i < 8; i++) begin
            send(0, i, 7 - i, 2, 1);
            expect_beats(0, 7 - i, i, 2);
        end
        @(negedge clk);
        check("t4_rv_pre", int'(rv8), 0);
        cyc();
        @(negedge clk);
        check("t4_rv_all", int'(rv8), 255);
        check("t4_rdy_all", int'(r8), 255);
        for (int j = 0; j < 8; j++)
            check($sformatf("t4_route%0d", j), int'(rt8[j*3 +: 3]), 7 - j);
        wait_idle();

        // move ptr[2] to 4, then reset during beat 2 of a 5-beat packet 6 -> 2
        send(0, 3, 2, 1, 1);
        expect_beats(0, 2, 3, 1);
        wait_idle();
        send(0, 6, 2, 5, 1);
        expect_beats(0, 2, 6, 2);
        @(negedge clk);
        check("t5_rv_pre", int'(rv8[2]), 0);
        cyc();
        @(negedge clk);
        check("t5_rdy_beat1", int'(r8[6]), 1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("t5_rdy_beat2", int'(r8[6]), 1);
        cyc();
        rst = 1'b0;
        abandon(0, 6);
        send(0, 0, 2, 1, 1);
        send(0, 6, 2, 1, 1);
        expect_beats(0, 2, 0, 1);
        expect_beats(0, 2, 6, 1);
        @(negedge clk);
        check("t5_rv_after_rst", int'(rv8[2]), 0);
        check("t5_route_after_rst", int'(rt8[6 +: 3]), 0);
        check("t5_rdy_after_rst", int'(r8[6]), 0);
        cyc();
        @(negedge clk);
        check("t5_rv_regrant", int'(rv8[2]), 1);
        check("t5_rdy0_regrant", int'(r8[0]), 1);
        wait_idle();

        // N=6: ptr[1] to 5 via input 4, then 5 and 0 contend; input 2 asks for dest 7
        send(1, 4, 1, 1, 1);
        expect_beats(1, 1, 4, 1);
        wait_idle();
        send(1, 5, 1, 2, 1);
        send(1, 0, 1, 2, 1);
        send(1, 2, 7, 1, 1);
        expect_beats(1, 1, 5, 2);
        expect_beats(1, 1, 0, 2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_oor_rdy_c%0d", k), int'(r6[2]), 0);
            cyc();
        end
        abandon(1, 2);
        wait_idle();

        for (int q = 0; q < 16; q++)
            check($sformatf("sb_left_q%0d", q), exp_q[q].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
